// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad calculator control sequencer
module calc_sequencer #(
    parameter logic [1:0] ADDR_A    = 2'd0,
    parameter logic [1:0] ADDR_B    = 2'd1,
    parameter logic [1:0] ADDR_R    = 2'd2,
    parameter int         EXEC_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [2:0] op_sel,
    input  logic       clear,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic [1:0] addr_a,
    output logic [1:0] addr_b,
    output logic [1:0] addr_wr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic [2:0] alu_op,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       zero_flag,
    output logic       busy,
    output logic       key_drop
);
    localparam logic [3:0] WAIT_INIT = 4'(EXEC_WAIT);

    typedef enum logic [2:0] {
        S_A_HI, S_A_LO, S_B_HI, S_B_LO, S_EXEC, S_WRBACK, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] nib_q, nib_d, cnt_q, cnt_d;
    logic [1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_wr_q, addr_wr_d;
    logic [7:0] wr_data_q, wr_data_d, result_q, result_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       wr_en_q, wr_en_d, rv_q, rv_d, zero_q, zero_d;
    logic       busy_q, busy_d, kd_q, kd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_A_HI;
            nib_q     <= '0;
            cnt_q     <= '0;
            addr_a_q  <= ADDR_R;
            addr_b_q  <= ADDR_B;
            addr_wr_q <= ADDR_A;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            alu_op_q  <= '0;
            result_q  <= '0;
            rv_q      <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            kd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_q     <= nib_d;
            cnt_q     <= cnt_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            addr_wr_q <= addr_wr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            alu_op_q  <= alu_op_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            kd_q      <= kd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        cnt_d     = cnt_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        addr_wr_d = addr_wr_q;
        wr_data_d = wr_data_q;
        alu_op_d  = alu_op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        rv_d      = 1'b0;
        kd_d      = 1'b0;
        if (clear) begin
            // A key arriving with clear is swallowed silently
            state_d  = S_A_HI;
            busy_d   = 1'b0;
            nib_d    = '0;
            result_d = '0;
            zero_d   = 1'b0;
        end else begin
            case (state_q)
                S_A_HI, S_DONE, S_B_HI: begin
                    if (key_valid) begin
                        nib_d   = key_code;
                        state_d = (state_q == S_B_HI) ? S_B_LO : S_A_LO;
                    end
                end
                S_A_LO: begin
                    if (key_valid) begin
                        wr_en_d   = 1'b1;
                        addr_wr_d = ADDR_A;
                        wr_data_d = {nib_q, key_code};
                        state_d   = S_B_HI;
                    end
                end
                S_B_LO: begin
                    if (key_valid) begin
                        wr_en_d   = 1'b1;
                        addr_wr_d = ADDR_B;
                        wr_data_d = {nib_q, key_code};
                        alu_op_d  = op_sel;
                        addr_a_d  = ADDR_A;
                        addr_b_d  = ADDR_B;
                        busy_d    = 1'b1;
                        cnt_d     = WAIT_INIT;
                        state_d   = S_EXEC;
                    end
                end
                S_EXEC: begin
                    kd_d = key_valid;
                    if (cnt_q == 4'd0) begin
                        result_d  = alu_result;
                        zero_d    = alu_zero;
                        wr_data_d = alu_result;
                        addr_wr_d = ADDR_R;
                        wr_en_d   = 1'b1;
                        rv_d      = 1'b1;
                        state_d   = S_WRBACK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_WRBACK: begin
                    kd_d     = key_valid;
                    busy_d   = 1'b0;
                    addr_a_d = ADDR_R;
                    state_d  = S_DONE;
                end
                default: state_d = S_A_HI;
            endcase
        end
    end

    assign addr_a       = addr_a_q;
    assign addr_b       = addr_b_q;
    assign addr_wr      = addr_wr_q;
    assign wr_data      = wr_data_q;
    assign wr_en        = wr_en_q;
    assign alu_op       = alu_op_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign zero_flag    = zero_q;
    assign busy         = busy_q;
    assign key_drop     = kd_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer (EXEC_WAIT 1 and 3)
module tb_calc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic [2:0] op_sel = '0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][7:0] alu_result_w, wr_data_w, result_w;
    logic [1:0][1:0] addr_a_w, addr_b_w, addr_wr_w;
    logic [1:0][2:0] alu_op_w;
    logic [1:0] alu_zero_w, wr_en_w, rv_w, zero_w, busy_w, kd_w;
    logic [7:0] bank0 [4];
    logic [7:0] bank1 [4];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    calc_sequencer #(.EXEC_WAIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .op_sel(op_sel), .clear(clear), .alu_result(alu_result_w[0]), .alu_zero(alu_zero_w[0]),
        .addr_a(addr_a_w[0]), .addr_b(addr_b_w[0]), .addr_wr(addr_wr_w[0]), .wr_data(wr_data_w[0]),
        .wr_en(wr_en_w[0]), .alu_op(alu_op_w[0]), .result(result_w[0]), .result_valid(rv_w[0]),
        .zero_flag(zero_w[0]), .busy(busy_w[0]), .key_drop(kd_w[0]));

    calc_sequencer #(.EXEC_WAIT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .op_sel(op_sel), .clear(clear), .alu_result(alu_result_w[1]), .alu_zero(alu_zero_w[1]),
        .addr_a(addr_a_w[1]), .addr_b(addr_b_w[1]), .addr_wr(addr_wr_w[1]), .wr_data(wr_data_w[1]),
        .wr_en(wr_en_w[1]), .alu_op(alu_op_w[1]), .result(result_w[1]), .result_valid(rv_w[1]),
        .zero_flag(zero_w[1]), .busy(busy_w[1]), .key_drop(kd_w[1]));

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a;
            3'd6: return b;
            default: return a << 1;
        endcase
    endfunction

    // Datapath environment: register bank plus ALU
    always @(posedge clk) if (wr_en_w[0]) bank0[addr_wr_w[0]] <= wr_data_w[0];
    always @(posedge clk) if (wr_en_w[1]) bank1[addr_wr_w[1]] <= wr_data_w[1];
    assign alu_result_w[0] = alu_f(bank0[addr_a_w[0]], bank0[addr_b_w[0]], alu_op_w[0]);
    assign alu_result_w[1] = alu_f(bank1[addr_a_w[1]], bank1[addr_b_w[1]], alu_op_w[1]);
    assign alu_zero_w[0]   = (alu_result_w[0] == 8'd0);
    assign alu_zero_w[1]   = (alu_result_w[1] == 8'd0);

    function automatic logic [7:0] bank_rd(input int k, input int i);
        return (k == 1) ? bank1[i] : bank0[i];
    endfunction

    // Reference model: digit count per calculation, capture scheduled by timestamp
    int         m_dcount [2];
    logic [3:0] m_dig [2][4];
    bit         m_calc [2];
    int         m_cap [2];
    logic [2:0] m_op [2];
    logic       e_wr [2], e_rv [2], e_kd [2], e_busy [2], e_zero [2];
    logic [1:0] e_awr [2], e_aa [2], e_ab [2];
    logic [7:0] e_wd [2], e_res [2];
    logic [2:0] e_op [2];
    logic [7:0] exp_bank [2][4];
    bit         exp_bv [2][4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset(input int k);
        m_dcount[k] = 0; m_calc[k] = 0; m_cap[k] = 0; m_op[k] = '0;
        e_wr[k] = 0; e_rv[k] = 0; e_kd[k] = 0; e_busy[k] = 0; e_zero[k] = 0;
        e_awr[k] = 2'd0; e_aa[k] = 2'd2; e_ab[k] = 2'd1;
        e_wd[k] = '0; e_res[k] = '0; e_op[k] = '0;
    endtask

    task automatic m_step(input int k);
        logic [7:0] r;
        if (e_wr[k]) begin
            exp_bank[k][e_awr[k]] = e_wd[k];
            exp_bv[k][e_awr[k]] = 1'b1;
        end
        e_wr[k] = 0; e_rv[k] = 0; e_kd[k] = 0;
        if (clear) begin
            m_dcount[k] = 0; m_calc[k] = 0;
            e_res[k] = '0; e_zero[k] = 0; e_busy[k] = 0;
        end else if (m_calc[k]) begin
            if (cyc == m_cap[k]) begin
                r = alu_f({m_dig[k][0], m_dig[k][1]}, {m_dig[k][2], m_dig[k][3]}, m_op[k]);
                e_res[k] = r; e_zero[k] = (r == 8'd0);
                e_wr[k] = 1; e_awr[k] = 2'd2; e_wd[k] = r; e_rv[k] = 1;
            end else if (cyc == m_cap[k] + 1) begin
                m_calc[k] = 0; m_dcount[k] = 0; e_busy[k] = 0; e_aa[k] = 2'd2;
            end
            if (key_valid) e_kd[k] = 1;
        end else if (key_valid) begin
            m_dig[k][m_dcount[k]] = key_code;
            if (m_dcount[k] == 1) begin
                e_wr[k] = 1; e_awr[k] = 2'd0; e_wd[k] = {m_dig[k][0], m_dig[k][1]};
            end
            if (m_dcount[k] == 3) begin
                e_wr[k] = 1; e_awr[k] = 2'd1; e_wd[k] = {m_dig[k][2], m_dig[k][3]};
                m_op[k] = op_sel; e_op[k] = op_sel; e_aa[k] = 2'd0; e_ab[k] = 2'd1;
                e_busy[k] = 1; m_calc[k] = 1;
                m_cap[k] = cyc + ((k == 1) ? 3 : 1) + 1;
            end
            m_dcount[k] = (m_dcount[k] + 1) % 4;
        end
    endtask

    always @(posedge clk) if (rst_n) begin
        cyc++;
        m_step(0);
        m_step(1);
    end

    always @(negedge rst_n) begin
        m_reset(0);
        m_reset(1);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.wr_en", k), wr_en_w[k], e_wr[k]);
            chk($sformatf("u%0d.result_valid", k), rv_w[k], e_rv[k]);
            chk($sformatf("u%0d.key_drop", k), kd_w[k], e_kd[k]);
            chk($sformatf("u%0d.busy", k), busy_w[k], e_busy[k]);
            chk($sformatf("u%0d.result", k), result_w[k], e_res[k]);
            chk($sformatf("u%0d.zero_flag", k), zero_w[k], e_zero[k]);
            chk($sformatf("u%0d.addr_a", k), addr_a_w[k], e_aa[k]);
            chk($sformatf("u%0d.addr_b", k), addr_b_w[k], e_ab[k]);
            chk($sformatf("u%0d.alu_op", k), alu_op_w[k], e_op[k]);
            if (e_wr[k]) begin
                chk($sformatf("u%0d.addr_wr", k), addr_wr_w[k], e_awr[k]);
                chk($sformatf("u%0d.wr_data", k), wr_data_w[k], e_wd[k]);
            end
            for (int i = 0; i < 4; i++)
                if (exp_bv[k][i]) chk($sformatf("u%0d.bank%0d", k, i), bank_rd(k, i), exp_bank[k][i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic seq4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [2:0] op);
        op_sel = op;
        press(a); press(b); press(c); press(d);
    endtask

    int bc0, bc1, rv0, rv1;

    initial begin
        m_reset(0);
        m_reset(1);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) exp_bv[k][i] = 1'b0;
        idle(2);
        chk("rst.addr_a", addr_a_w[0], 2);
        chk("rst.addr_b", addr_b_w[0], 1);
        chk("rst.addr_wr", addr_wr_w[0], 0);
        chk("rst.wr_en", wr_en_w[0], 0);
        chk("rst.busy", busy_w[0], 0);
        rst_n = 1'b1;
        idle(1);

        // 0x3C + 0x05: capture two edges after the B_LO key (u0), four edges (u1)
        seq4(4'h3, 4'hC, 4'h0, 4'h5, 3'd0);
        idle(2);
        chk("add.rv", rv_w[0], 1);
        chk("add.wr_en", wr_en_w[0], 1);
        chk("add.addr_wr", addr_wr_w[0], 2);
        chk("add.wr_data", wr_data_w[0], 8'h41);
        chk("add.result", result_w[0], 8'h41);
        chk("add.zero", zero_w[0], 0);
        idle(2);
        chk("add_w3.rv", rv_w[1], 1);
        chk("add_w3.result", result_w[1], 8'h41);
        idle(4);
        chk("add.r0", bank0[0], 8'h3C);
        chk("add.r1", bank0[1], 8'h05);
        chk("add.r2", bank0[2], 8'h41);

        seq4(4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        idle(6);
        chk("zero.result", result_w[0], 0);
        chk("zero.flag", zero_w[0], 1);
        chk("zero.r2", bank0[2], 0);

        // Timing window: result_valid offset and busy length per EXEC_WAIT
        seq4(4'h1, 4'h2, 4'h3, 4'h4, 3'd0);
        bc0 = busy_w[0] ? 1 : 0; bc1 = busy_w[1] ? 1 : 0; rv0 = -1; rv1 = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (busy_w[0]) bc0++;
            if (busy_w[1]) bc1++;
            if (rv_w[0] && rv0 < 0) rv0 = i;
            if (rv_w[1] && rv1 < 0) rv1 = i;
        end
        chk("w1.rv_delay", rv0, 2);
        chk("w1.busy_len", bc0, 3);
        chk("w3.rv_delay", rv1, 4);
        chk("w3.busy_len", bc1, 5);
        chk("w3.result", result_w[1], 8'h46);

        // Keys during EXEC/WRBACK are dropped
        seq4(4'h8, 4'h1, 4'h0, 4'h2, 3'd1);
        press(4'h9); chk("drop1", kd_w[0], 1);
        press(4'hA); chk("drop2", kd_w[0], 1);
        press(4'hB); chk("drop3", kd_w[0], 1);
        idle(6);
        chk("drop.result", result_w[0], 8'h7F);
        press(4'hD); press(4'hE);
        idle(2);
        chk("done.r0", bank0[0], 8'hDE);
        op_sel = 3'd2;
        press(4'h0); press(4'h1);
        idle(6);

        // clear in B_HI, then coincident clear + key
        seq4(4'h1, 4'h1, 4'h2, 4'h2, 3'd3);
        idle(6);
        chk("or.result", result_w[0], 8'h33);
        press(4'h7); press(4'h1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr.result", result_w[0], 0);
        chk("clr.busy", busy_w[0], 0);
        clear = 1'b1; key_valid = 1'b1; key_code = 4'h5; tick();
        clear = 1'b0; key_valid = 1'b0;
        chk("clr.key_drop", kd_w[0], 0);
        seq4(4'h2, 4'h0, 4'h0, 4'h3, 3'd0);
        idle(6);
        chk("clr.after_r0", bank0[0], 8'h20);
        chk("clr.after_result", result_w[0], 8'h23);

        // Reset in EXEC abandons the write-back
        seq4(4'h4, 4'h4, 4'h4, 4'h4, 3'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstx.wr_en0", wr_en_w[0], 0);
        chk("rstx.busy0", busy_w[0], 0);
        chk("rstx.busy1", busy_w[1], 0);
        idle(2);
        rst_n = 1'b1;
        idle(6);
        chk("rstx.r2", bank0[2], 8'h23);
        chk("rstx.result", result_w[0], 0);
        seq4(4'h0, 4'hA, 4'h0, 4'hB, 3'd0);
        idle(6);
        chk("rstx.after_result", result_w[0], 8'h15);
        chk("rstx.after_r2", bank0[2], 8'h15);

        // Random keys, ops, gaps and clears
        for (int n = 0; n < 400; n++) begin
            op_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) begin
                clear = 1'b1;
                key_valid = 1'($urandom_range(0, 1));
                key_code = 4'($urandom_range(0, 15));
                tick();
                clear = 1'b0;
                key_valid = 1'b0;
            end else begin
                press(4'($urandom_range(0, 15)));
            end
            idle($urandom_range(0, 3));
        end
        idle(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
